// File: rtl/alu_datapath.sv
// ALU datapath: 32-bit combinational ALU, write-back register/data select
// muxes, and a one-cycle registered write-back stage.
module alu_datapath (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] alu_inputA,
  input  logic [31:0] alu_inputB,
  input  logic [3:0]  alu_control,
  input  logic [3:0]  dest_rd,
  input  logic [3:0]  dest_rt,
  input  logic [31:0] imm_ext,
  input  logic        C_ART_reg,
  input  logic        C_ART_data,
  input  logic        regWrite_in,
  output logic [31:0] alu_output,
  output logic        alu_cout,
  output logic        alu_zero,
  output logic [3:0]  writeReg,
  output logic [31:0] writeData,
  output logic        regWrite
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_NOR  = 4'b0101,
    OP_SLL  = 4'b0110,
    OP_SRL  = 4'b0111,
    OP_SRA  = 4'b1000,
    OP_SLT  = 4'b1001,
    OP_SLTU = 4'b1010,
    OP_PASS = 4'b1011
  } alu_op_t;

  logic [32:0] sum_ext;
  logic [4:0]  shamt;
  logic [3:0]  write_reg_next;
  logic [31:0] write_data_next;

  assign shamt = alu_inputB[4:0];

  // ALU: result and carry; subtract is A + ~B + 1 so carry means A >= B unsigned
  always_comb begin
    alu_output = '0;
    alu_cout   = 1'b0;
    sum_ext    = '0;
    case (alu_control)
      OP_ADD: begin
        sum_ext    = {1'b0, alu_inputA} + {1'b0, alu_inputB};
        alu_output = sum_ext[31:0];
        alu_cout   = sum_ext[32];
      end
      OP_SUB: begin
        sum_ext    = {1'b0, alu_inputA} + {1'b0, ~alu_inputB} + 33'd1;
        alu_output = sum_ext[31:0];
        alu_cout   = sum_ext[32];
      end
      OP_AND:  alu_output = alu_inputA & alu_inputB;
      OP_OR:   alu_output = alu_inputA | alu_inputB;
      OP_XOR:  alu_output = alu_inputA ^ alu_inputB;
      OP_NOR:  alu_output = ~(alu_inputA | alu_inputB);
      OP_SLL:  alu_output = alu_inputA << shamt;
      OP_SRL:  alu_output = alu_inputA >> shamt;
      OP_SRA:  alu_output = 32'($signed(alu_inputA) >>> shamt);
      OP_SLT:  alu_output = {31'b0, $signed(alu_inputA) < $signed(alu_inputB)};
      OP_SLTU: alu_output = {31'b0, alu_inputA < alu_inputB};
      OP_PASS: alu_output = alu_inputB;
      default: alu_output = '0;
    endcase
  end

  assign alu_zero = (alu_output == '0);

  // Write-back source muxes: AR-type vs T-type destination and data
  always_comb begin
    write_reg_next  = C_ART_reg  ? dest_rt : dest_rd;
    write_data_next = C_ART_data ? imm_ext : alu_output;
  end

  // Write-back stage loads every cycle; reset clears it immediately
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      writeReg  <= '0;
      writeData <= '0;
      regWrite  <= 1'b0;
    end else begin
      writeReg  <= write_reg_next;
      writeData <= write_data_next;
      regWrite  <= regWrite_in;
    end
  end

endmodule

// File: tb/tb_alu_datapath.sv
// Directed bench for alu_datapath with a write-back scoreboard queue.
module tb_alu_datapath;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] alu_inputA, alu_inputB, imm_ext;
  logic [3:0]  alu_control, dest_rd, dest_rt;
  logic        C_ART_reg, C_ART_data, regWrite_in;
  logic [31:0] alu_output, writeData;
  logic        alu_cout, alu_zero, regWrite;
  logic [3:0]  writeReg;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  wreg;
    logic [31:0] wdata;
    logic        we;
  } wb_t;

  wb_t sb[$];

  alu_datapath dut (
    .CLK(CLK), .RESET(RESET),
    .alu_inputA(alu_inputA), .alu_inputB(alu_inputB),
    .alu_control(alu_control), .dest_rd(dest_rd), .dest_rt(dest_rt),
    .imm_ext(imm_ext), .C_ART_reg(C_ART_reg), .C_ART_data(C_ART_data),
    .regWrite_in(regWrite_in), .alu_output(alu_output), .alu_cout(alu_cout),
    .alu_zero(alu_zero), .writeReg(writeReg), .writeData(writeData),
    .regWrite(regWrite)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctrl,
                       input logic [3:0] rd, input logic [3:0] rt, input logic [31:0] imm,
                       input logic sr, input logic sd, input logic we);
    alu_inputA  = a;
    alu_inputB  = b;
    alu_control = ctrl;
    dest_rd     = rd;
    dest_rt     = rt;
    imm_ext     = imm;
    C_ART_reg   = sr;
    C_ART_data  = sd;
    regWrite_in = we;
  endtask

  // Drive one operation, check combinational outputs, then check write-back after the edge
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] ctrl, input logic [3:0] rd, input logic [3:0] rt,
                      input logic [31:0] imm, input logic sr, input logic sd, input logic we,
                      input logic [31:0] eo, input logic ec, input logic ez);
    wb_t e;
    drive(a, b, ctrl, rd, rt, imm, sr, sd, we);
    #1;
    check({tag, "_out"},  alu_output, eo);
    check({tag, "_cout"}, {31'b0, alu_cout}, {31'b0, ec});
    check({tag, "_zero"}, {31'b0, alu_zero}, {31'b0, ez});
    e.wreg  = sr ? rt : rd;
    e.wdata = sd ? imm : eo;
    e.we    = we;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_sb: observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_wreg"},  {28'b0, writeReg}, {28'b0, e.wreg});
      check({tag, "_wdata"}, writeData, e.wdata);
      check({tag, "_we"},    {31'b0, regWrite}, {31'b0, e.we});
    end
  endtask

  initial begin
    RESET = 1'b0;
    drive(32'd0, 32'd0, 4'd0, 4'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("rst_wreg",  {28'b0, writeReg}, 32'd0);
    check("rst_wdata", writeData, 32'd0);
    check("rst_we",    {31'b0, regWrite}, 32'd0);
    #2 RESET = 1'b1;
    @(posedge CLK);
    #1;

    step("ar_add",  32'd5, 32'd7, 4'b0000, 4'd9, 4'd3, 32'h0, 1'b0, 1'b0, 1'b1, 32'd12, 1'b0, 1'b0);
    step("t_type",  32'd5, 32'd7, 4'b0000, 4'd9, 4'd2, 32'hFFFFFFFC, 1'b1, 1'b1, 1'b1, 32'd12, 1'b0, 1'b0);
    step("add_wrap", 32'hFFFFFFFF, 32'd1, 4'b0000, 4'd1, 4'd0, 32'h0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 1'b1);
    step("sub_neg", 32'd3, 32'd5, 4'b0001, 4'd4, 4'd0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    step("sub_pos", 32'd5, 32'd3, 4'b0001, 4'd5, 4'd0, 32'h0, 1'b0, 1'b0, 1'b1, 32'd2, 1'b1, 1'b0);
    step("sub_eq",  32'd5, 32'd5, 4'b0001, 4'd6, 4'd0, 32'h0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 1'b1);
    step("and", 32'hF0F0F0F0, 32'hFF00FF00, 4'b0010, 4'd7, 4'd0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hF000F000, 1'b0, 1'b0);
    step("or",  32'hF0F0F0F0, 32'hFF00FF00, 4'b0011, 4'd8, 4'd0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFF0FFF0, 1'b0, 1'b0);
    step("xor", 32'hF0F0F0F0, 32'hFF00FF00, 4'b0100, 4'd8, 4'd0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0FF00FF0, 1'b0, 1'b0);
    step("nor", 32'hF0F0F0F0, 32'hFF00FF00, 4'b0101, 4'd8, 4'd0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h000F000F, 1'b0, 1'b0);
    step("slt",  32'h80000000, 32'd1, 4'b1001, 4'd10, 4'd0, 32'h0, 1'b0, 1'b0, 1'b1, 32'd1, 1'b0, 1'b0);
    step("sltu", 32'h80000000, 32'd1, 4'b1010, 4'd11, 4'd0, 32'h0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b1);
    step("sra",  32'h80000000, 32'd1, 4'b1000, 4'd12, 4'd0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hC0000000, 1'b0, 1'b0);
    step("srl",  32'h80000000, 32'd1, 4'b0111, 4'd13, 4'd0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h40000000, 1'b0, 1'b0);
    step("sll33", 32'd1, 32'd33, 4'b0110, 4'd14, 4'd0, 32'h0, 1'b0, 1'b0, 1'b1, 32'd2, 1'b0, 1'b0);
    step("sra36", 32'h80000000, 32'h00000024, 4'b1000, 4'd15, 4'd0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hF8000000, 1'b0, 1'b0);
    step("passb", 32'hDEADBEEF, 32'h12345678, 4'b1011, 4'd3, 4'd0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0);
    step("we0",  32'd2, 32'd2, 4'b0000, 4'd1, 4'd6, 32'h55, 1'b1, 1'b0, 1'b0, 32'd4, 1'b0, 1'b0);
    for (int op = 12; op < 16; op++)
      step("undef", 32'hFFFFFFFF, 32'd1, 4'(op), 4'd2, 4'd0, 32'h0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b1);

    // Mid-operation reset: pending write-back must be dropped
    step("pre_rst", 32'd1, 32'd2, 4'b0000, 4'd5, 4'd0, 32'h0, 1'b0, 1'b0, 1'b1, 32'd3, 1'b0, 1'b0);
    drive(32'd10, 32'd20, 4'b0000, 4'd6, 4'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    #2 RESET = 1'b0;
    sb.delete();
    #1;
    check("async_rst_wreg",  {28'b0, writeReg}, 32'd0);
    check("async_rst_wdata", writeData, 32'd0);
    check("async_rst_we",    {31'b0, regWrite}, 32'd0);
    check("rst_alu_live",    alu_output, 32'd30);
    repeat (2) @(posedge CLK);
    #1;
    check("held_rst_wreg",  {28'b0, writeReg}, 32'd0);
    check("held_rst_wdata", writeData, 32'd0);
    check("held_rst_we",    {31'b0, regWrite}, 32'd0);
    #2 RESET = 1'b1;
    @(posedge CLK);
    #1;
    check("post_rst_wreg",  {28'b0, writeReg}, 32'd6);
    check("post_rst_wdata", writeData, 32'd30);
    check("post_rst_we",    {31'b0, regWrite}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_datapath.md
ALU_DATAPATH -- requirements
Module: alu_datapath

Interface
REQ-001 Parameters SHALL be none: data width fixed at 32 bits, register index 4 bits, ALU control 4 bits.
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-003 Port CLK  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port RESET  in  1  asynchronous, active-low reset.
REQ-005 Port alu_inputA  in  32  ALU operand A (register read port 1).
REQ-006 Port alu_inputB  in  32  ALU operand B (register read port 2).
REQ-007 Port alu_control  in  4  ALU operation select.
REQ-008 Port dest_rd  in  4  AR-type destination index, instr[14:11].
REQ-009 Port dest_rt  in  4  T-type destination index, instr[22:19].
REQ-010 Port imm_ext  in  32  sign-extended T-type constant.
REQ-011 Port C_ART_reg  in  1  write-register mux select: 0 picks dest_rd, 1 picks dest_rt.
REQ-012 Port C_ART_data  in  1  write-data mux select: 0 picks ALU result, 1 picks imm_ext.
REQ-013 Port regWrite_in  in  1  write-enable from the controller.
REQ-014 Port alu_output  out  32  combinational ALU result.
REQ-015 Port alu_cout  out  1  combinational ALU carry.
REQ-016 Port alu_zero  out  1  combinational; 1 when alu_output == 0.
REQ-017 Port writeReg  out  4  registered write-back register index.
REQ-018 Port writeData  out  32  registered write-back data.
REQ-019 Port regWrite  out  1  registered write-enable, aligned with writeReg/writeData.

Function
REQ-020 The block SHALL contain one 4-bit 2:1 mux (writeReg source), one 32-bit 2:1 mux (writeData source) and one 32-bit ALU; all are purely combinational.
REQ-021 ALU ops (alu_control -> alu_output) SHALL be: 0000 A+B; 0001 A-B; 0010 A&B; 0011 A|B; 0100 A^B; 0101 ~(A|B); 0110 A<<B[4:0]; 0111 A>>B[4:0] logical; 1000 A>>>B[4:0] arithmetic; 1001 signed A<B ? 1 : 0; 1010 unsigned A<B ? 1 : 0; 1011 pass B; 1100-1111 result 0.
REQ-022 Add/subtract SHALL wrap modulo 2^32 with no overflow trap.
REQ-023 alu_cout SHALL be the carry out of bit 31 for ADD, and for SUB the carry of A + ~B + 1 (1 when A >= B unsigned); 0 for all other ops.
REQ-024 Shift amounts SHALL use only B[4:0]; B[31:5] are ignored.
REQ-025 Each mux output SHALL follow its inputs and select combinationally, with no latch inferred.
REQ-026 On each rising CLK edge with RESET high: writeReg <= mux4 output, writeData <= mux32 output, regWrite <= regWrite_in, giving a latency of exactly 1 cycle.
REQ-027 The write-back registers SHALL load every cycle irrespective of regWrite_in; the index and data in a cycle with regWrite = 0 carry no meaning.
REQ-028 alu_output, alu_cout and alu_zero SHALL be unaffected by clock and reset.

Reset
REQ-029 RESET low SHALL immediately, without waiting for CLK, force writeReg = 0, writeData = 0 and regWrite = 0.
REQ-030 While RESET is low, CLK edges SHALL not change the registered outputs.
REQ-031 After RESET rises, the first rising CLK edge SHALL capture live inputs.
REQ-032 Asserting RESET mid-operation SHALL discard the pending write-back, so no regWrite pulse escapes.

Verification
REQ-033 AR add: A = 5, B = 7, ctrl 0000, C_ART_reg 0, C_ART_data 0, dest_rd 9, regWrite_in 1 -> alu_output 12 at once; next edge writeReg 9, writeData 12, regWrite 1.
REQ-034 T-type: imm_ext 0xFFFFFFFC, dest_rt 2, dest_rd 9, both selects 1 -> after the edge writeReg 2, writeData 0xFFFFFFFC.
REQ-035 Carry and wrap: A = 0xFFFFFFFF, B = 1, ADD -> 0, cout 1, zero 1; SUB with A = 3, B = 5 -> 0xFFFFFFFE, cout 0.
REQ-036 Compare and shift: A = 0x80000000, B = 1 -> SLT 1, SLTU 0, SRA 0xC0000000, SRL 0x40000000; B = 33 with SLL and A = 1 -> 2.
REQ-037 Reset: drive regWrite 1 state, pull RESET low between edges -> outputs become 0 before the next edge and stay 0 through clock edges; release -> capture resumes on the next edge.
REQ-038 Undefined ops: ctrl 1100-1111 with any A/B -> alu_output 0, cout 0, zero 1.
